// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache line <-> memory burst adaptor.
//   cacheline_t     : one full cache line (256 bits)
//   burst_t         : one memory beat (64 bits)
//   LINE_BEATS      : beats per line
//   OFFSET_BITS     : byte-offset bits stripped to line-align an address
//   CNT_W           : width of the beat counter
//   adaptor_state_t : adaptor FSM states
package cacheline_adaptor_pkg;

  typedef logic [255:0] cacheline_t;
  typedef logic [63:0]  burst_t;

  localparam int LINE_BEATS  = 4;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BURST,
    WR_BURST,
    DONE
  } adaptor_state_t;

endpackage : cacheline_adaptor_pkg

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line interface to a 64-bit, 4-beat memory burst
// interface. One line transaction is in flight at a time.
//
// Ports (cache side):
//   line_i    : line to write back, captured when the write is accepted
//   line_o    : assembled fill line, valid in the resp_o cycle, held until
//               the next read overwrites it beat by beat
//   address_i : byte address of the request
//   read_i    : fill request (level, held until resp_o)
//   write_i   : writeback request (level, held until resp_o); wins over read_i
//   resp_o    : one-cycle completion pulse
// Ports (memory side):
//   burst_i   : read beat from memory
//   burst_o   : write beat to memory
//   address_o : line-aligned address, stable for the whole transaction
//   read_o    : memory read request (drops after the first beat)
//   write_o   : memory write request (held until the last beat is taken)
//   resp_i    : beat handshake from memory
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;

  adaptor_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] wbeat_q [BEATS];
  logic [BURST_W-1:0] wbeat_d [BEATS];
  logic [BURST_W-1:0] rbeat_q [BEATS];
  logic [BURST_W-1:0] rbeat_d [BEATS];
  logic [BURST_W-1:0] line_in_beats [BEATS];
  logic [ADDR_W-1:0]  aligned_addr;
  logic               last_beat;

  // Byte-offset bits inside the line are irrelevant to memory.
  logic unused_offset;
  assign unused_offset = ^address_i[OFFSET_BITS-1:0];

  assign aligned_addr = {address_i[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));

  // View the lines as arrays of beats so the beat counter indexes directly.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign line_in_beats[gi]                 = line_i[gi*BURST_W +: BURST_W];
    assign line_o[gi*BURST_W +: BURST_W]     = rbeat_q[gi];
  end

  // Address and write beat come straight from registers so they only move
  // on a handshake (or when a new request is accepted).
  assign address_o = addr_q;
  assign burst_o   = wbeat_q[cnt_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbeat_q <= '{default: '0};
      rbeat_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbeat_d = wbeat_q;
    rbeat_d = rbeat_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          wbeat_d = line_in_beats;
          addr_d  = aligned_addr;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = aligned_addr;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        read_o = 1'b1;
        if (resp_i) begin
          rbeat_d[cnt_q] = burst_i;
          cnt_d          = cnt_q + CNT_W'(1);
          state_d        = last_beat ? DONE : RD_BURST;
        end
      end

      RD_BURST: begin
        // Memory may stall between beats; only a handshake advances.
        if (resp_i) begin
          rbeat_d[cnt_q] = burst_i;
          cnt_d          = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      WR_BURST: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        resp_o  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor: read fill, writeback, stalled
// memory, simultaneous requests, mid-burst reset and back-to-back requests.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  cacheline_t  line_i, line_o;
  logic [31:0] address_i, address_o;
  logic        read_i, write_i, resp_o;
  burst_t      burst_i, burst_o;
  logic        read_o, write_o, resp_i;

  int n_tests = 0;
  int n_fail  = 0;
  int gap_q [4];

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Read fill. The bench plays memory: it answers once read_o is seen,
  // inserting gap_q[k] idle cycles before beat k.
  task automatic run_read(input logic [31:0] addr, input burst_t b0, input burst_t b1,
                          input burst_t b2, input burst_t b3, input int exp_lat,
                          input bit chain);
    burst_t      beats [4];
    logic [31:0] aligned;
    int          beat, wait_n, lat;
    bit          started, done;
    beats   = '{b0, b1, b2, b3};
    aligned = {addr[31:5], 5'b0};
    @(negedge clk);
    address_i = addr;
    read_i    = 1'b1;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    lat = 1; beat = 0; started = 0; done = 0; wait_n = gap_q[0];
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (resp_o) begin
        done = 1;
        check_eq("rd_beats_before_resp", 256'(beat), 256'(4));
        check_eq("rd_latency", 256'(lat), 256'(exp_lat));
        check_eq("rd_line_o", line_o, {beats[3], beats[2], beats[1], beats[0]});
        check_eq("rd_read_o_low_done", 256'(read_o), 256'(0));
        read_i = 1'b0;
        resp_i = 1'b0;
      end else begin
        resp_i = 1'b0;
        if (read_o) started = 1;
        if (started) check_eq("rd_address_o", 256'(address_o), 256'(aligned));
        if (beat >= 1) check_eq("rd_read_o_dropped", 256'(read_o), 256'(0));
        if (started && beat < 4) begin
          if (wait_n > 0) begin
            wait_n--;
          end else begin
            resp_i  = 1'b1;
            burst_i = beats[beat];
            beat++;
            if (beat < 4) wait_n = gap_q[beat];
          end
        end
      end
    end
    check_eq("rd_read_o_seen", 256'(started), 256'(1));
    if (!done) check_eq("rd_timeout_resp_o", 256'(0), 256'(1));
    if (!chain) begin
      @(negedge clk);
      check_eq("rd_resp_one_cycle", 256'(resp_o), 256'(0));
    end
  endtask

  // Writeback with line {d,c,b,a}. abort_after>0 pulses rst once that many
  // beats have been consumed.
  task automatic run_write(input logic [31:0] addr, input burst_t a, input burst_t b,
                           input burst_t c, input burst_t d, input bit also_read,
                           input bit start_now, input int abort_after);
    burst_t      beats [4];
    cacheline_t  line_before;
    logic [31:0] aligned;
    int          beat, wait_n;
    bit          started, done, saw_read, aborted;
    beats   = '{a, b, c, d};
    aligned = {addr[31:5], 5'b0};
    if (!start_now) @(negedge clk);
    line_before = line_o;
    line_i    = {d, c, b, a};
    address_i = addr;
    write_i   = 1'b1;
    read_i    = also_read;
    resp_i    = 1'b0;
    beat = 0; started = 0; done = 0; saw_read = 0; aborted = 0; wait_n = gap_q[0];
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (read_o) saw_read = 1;
      if (resp_o) begin
        done = 1;
        check_eq("wr_beats_before_resp", 256'(beat), 256'(4));
        check_eq("wr_write_o_low_done", 256'(write_o), 256'(0));
        check_eq("wr_line_o_unchanged", line_o, line_before);
        write_i = 1'b0;
        read_i  = 1'b0;
        resp_i  = 1'b0;
      end else begin
        resp_i = 1'b0;
        if (write_o) started = 1;
        if (started) begin
          check_eq("wr_write_o", 256'(write_o), 256'(1));
          check_eq("wr_address_o", 256'(address_o), 256'(aligned));
          if (beat < 4) check_eq("wr_burst_o", 256'(burst_o), 256'(beats[beat]));
          else check_eq("wr_extra_beat", 256'(beat), 256'(3));
          if (abort_after > 0 && beat == abort_after) begin
            rst     = 1'b1;
            write_i = 1'b0;
            read_i  = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq("rst_write_o", 256'(write_o), 256'(0));
            check_eq("rst_read_o", 256'(read_o), 256'(0));
            check_eq("rst_resp_o", 256'(resp_o), 256'(0));
            check_eq("rst_address_o", 256'(address_o), 256'(0));
            check_eq("rst_burst_o", 256'(burst_o), 256'(0));
            check_eq("rst_line_o", line_o, 256'(0));
            rst = 1'b0;
            @(negedge clk);
            check_eq("rst_stays_idle", 256'({resp_o, write_o, read_o}), 256'(0));
            aborted = 1;
            done    = 1;
          end else if (beat < 4) begin
            if (wait_n > 0) begin
              wait_n--;
            end else begin
              resp_i = 1'b1;
              beat++;
              if (beat < 4) wait_n = gap_q[beat];
            end
          end
        end
      end
    end
    check_eq("wr_no_read_o", 256'(saw_read), 256'(0));
    if (!done) check_eq("wr_timeout_resp_o", 256'(0), 256'(1));
    if (!aborted) begin
      @(negedge clk);
      check_eq("wr_resp_one_cycle", 256'(resp_o), 256'(0));
    end
  endtask

  localparam burst_t B1 = 64'h1111_1111_1111_1111;
  localparam burst_t B2 = 64'h2222_2222_2222_2222;
  localparam burst_t B3 = 64'h3333_3333_3333_3333;
  localparam burst_t B4 = 64'h4444_4444_4444_4444;
  localparam burst_t BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam burst_t BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam burst_t BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam burst_t BD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam burst_t B5 = 64'h5555_6666_7777_8888;
  localparam burst_t B6 = 64'h9999_0000_1234_5678;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    gap_q = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_line_o", line_o, 256'(0));
    check_eq("reset_burst_o", 256'(burst_o), 256'(0));
    check_eq("reset_address_o", 256'(address_o), 256'(0));
    check_eq("reset_read_o", 256'(read_o), 256'(0));
    check_eq("reset_write_o", 256'(write_o), 256'(0));
    check_eq("reset_resp_o", 256'(resp_o), 256'(0));
    rst = 1'b0;

    // Read fill at full memory speed: 6-cycle latency.
    gap_q = '{0, 0, 0, 0};
    run_read(32'h0000_1234, B1, B2, B3, B4, 6, 1'b0);

    // Writeback, offset bits stripped from 0x8000_003F.
    run_write(32'h8000_003F, BA, BB, BC, BD, 1'b0, 1'b0, 0);

    // Stalled memory on read and write.
    gap_q = '{2, 0, 3, 1};
    run_read(32'h0000_2010, B1, B2, B3, B4, 12, 1'b0);
    gap_q = '{1, 3, 0, 2};
    run_write(32'h0000_4000, BA, BB, BC, BD, 1'b0, 1'b0, 0);

    // Simultaneous read and write: write wins.
    gap_q = '{0, 0, 0, 0};
    run_write(32'h1234_5678, BD, BC, BB, BA, 1'b1, 1'b0, 0);

    // Reset after the second write beat, then a normal read.
    run_write(32'h8000_0040, BA, BB, BC, BD, 1'b0, 1'b0, 2);
    run_read(32'h0000_0100, B4, B3, B2, B1, 6, 1'b0);

    // Back-to-back: read, then a write raised right at resp_o.
    run_read(32'h0000_0200, B5, B6, B1, B2, 6, 1'b1);
    run_write(32'h0000_0300, BA, BB, BC, BD, 1'b0, 1'b1, 0);
    check_eq("b2b_line_o_after_write", line_o, {B2, B1, B6, B5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cacheline_adaptor
